trdb_trace_ctrl: RTL and testbench

// Activation/qualification controller sitting downstream of trdb_filter and upstream of the packet emitter.
// - Owns the trace-activated state that trdb_filter consumes; honours its deactivate requests.
// - Converts per-instruction qualified levels into discrete START/STOP events for the packetizer.
// - Events are delivered over a one-entry valid/ready register; drops and qualified instructions are counted.

---
 rtl/trdb_pkg.sv | 22 ++
 rtl/trdb_trace_ctrl_if.sv | 17 +
 rtl/trdb_evt_reg.sv | 45 ++++
 rtl/trdb_trace_ctrl.sv | 155 +++++++++++++++
 tb/tb_trdb_trace_ctrl.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/trdb_pkg.sv
// Shared types for the trace debug slice.
// Holds the architectural address width, the trace controller state
// encoding, the START/STOP event codes and the packed event record.
package trdb_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    OFF     = 2'd0,
    ARMED   = 2'd1,
    TRACING = 2'd2
  } trdb_ctrl_state_e;

  localparam logic EVT_START = 1'b0;
  localparam logic EVT_STOP  = 1'b1;

  typedef struct packed {
    logic            typ;
    logic [XLEN-1:0] addr;
  } trdb_evt_t;

endpackage

// File: rtl/trdb_trace_ctrl_if.sv
// Event channel from the trace controller to the packet emitter.
//   evt_valid  event pending
//   evt_ready  packetizer accepts the event
//   evt_type   EVT_START / EVT_STOP
//   evt_addr   address carried by the event
// master: controller side, slave: packetizer side.
interface trdb_trace_ctrl_if
  import trdb_pkg::*;
  ;
  logic            evt_valid;
  logic            evt_ready;
  logic            evt_type;
  logic [XLEN-1:0] evt_addr;

  modport master (output evt_valid, output evt_type, output evt_addr, input evt_ready);
  modport slave  (input evt_valid, input evt_type, input evt_addr, output evt_ready);
endinterface

// File: rtl/trdb_evt_reg.sv
// Single-entry valid/ready holding register for trace events.
//   clk_i, rst_ni  clock, asynchronous active-low reset
//   in_valid_i     a new event is offered this cycle
//   in_evt_i       the offered event
//   out_ready_i    consumer accepts the held event
//   out_valid_o    an event is held
//   out_evt_o      the held event (stable while out_valid_o & !out_ready_i)
//   drop_o         strobe: the offered event could not be stored
module trdb_evt_reg
  import trdb_pkg::*;
(
  input  logic      clk_i,
  input  logic      rst_ni,
  input  logic      in_valid_i,
  input  trdb_evt_t in_evt_i,
  input  logic      out_ready_i,
  output logic      out_valid_o,
  output trdb_evt_t out_evt_o,
  output logic      drop_o
);

  logic      valid_q;
  trdb_evt_t evt_q;
  logic      load;

  // The slot is free when empty or being drained in this same cycle.
  assign load   = in_valid_i & (~valid_q | out_ready_i);
  assign drop_o = in_valid_i & valid_q & ~out_ready_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      evt_q   <= '0;
    end else if (load) begin
      valid_q <= 1'b1;
      evt_q   <= in_evt_i;
    end else if (out_ready_i) begin
      valid_q <= 1'b0;
    end
  end

  assign out_valid_o = valid_q;
  assign out_evt_o   = evt_q;

endmodule

// File: rtl/trdb_trace_ctrl.sv
// Trace activation/qualification controller.
// Owns the trace-activated state used by the filter, turns per-instruction
// qualification levels into START/STOP events and counts qualified
// instructions and dropped events (both saturating).
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   user_activate_i          pulse: activate tracing
//   user_deactivate_i        pulse: deactivate tracing
//   clear_i                  pulse: clear counters and overflow_o
//   ivalid_i, iaddr_i        retired instruction and its address
//   trace_qualified_i        filter qualification level
//   trace_req_deactivate_i   filter deactivation request
//   trace_activated_o        state != OFF
//   evt                      event channel (master)
//   state_o                  current controller state
//   qual_cnt_o, drop_cnt_o   saturating counters
//   overflow_o               sticky: an event was dropped
module trdb_trace_ctrl
  import trdb_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               user_activate_i,
  input  logic               user_deactivate_i,
  input  logic               clear_i,
  input  logic               ivalid_i,
  input  logic [XLEN-1:0]    iaddr_i,
  input  logic               trace_qualified_i,
  input  logic               trace_req_deactivate_i,
  output logic               trace_activated_o,
  trdb_trace_ctrl_if.master  evt,
  output logic [1:0]         state_o,
  output logic [CNT_W-1:0]   qual_cnt_o,
  output logic [CNT_W-1:0]   drop_cnt_o,
  output logic               overflow_o
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  trdb_ctrl_state_e state_q;
  logic             activated_q;
  logic [XLEN-1:0]  last_addr_q;
  logic [CNT_W-1:0] qual_cnt_q;
  logic [CNT_W-1:0] drop_cnt_q;
  logic             overflow_q;

  logic      deact;
  logic      qual_hit;
  logic      unqual_hit;
  logic      new_valid;
  trdb_evt_t new_evt;
  logic      drop;
  logic      out_valid;
  trdb_evt_t out_evt;

  assign deact      = user_deactivate_i | (ivalid_i & trace_req_deactivate_i);
  assign qual_hit   = ivalid_i & trace_qualified_i;
  assign unqual_hit = ivalid_i & ~trace_qualified_i;

  // STOP always reports last_addr_q before this cycle's update.
  always_comb begin
    new_valid = 1'b0;
    new_evt   = '0;
    unique case (state_q)
      ARMED: begin
        if (!deact && qual_hit) begin
          new_valid = 1'b1;
          new_evt   = '{typ: EVT_START, addr: iaddr_i};
        end
      end
      TRACING: begin
        if (deact || unqual_hit) begin
          new_valid = 1'b1;
          new_evt   = '{typ: EVT_STOP, addr: last_addr_q};
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= OFF;
      activated_q <= 1'b0;
      last_addr_q <= '0;
      qual_cnt_q  <= '0;
      drop_cnt_q  <= '0;
      overflow_q  <= 1'b0;
    end else begin
      if (deact) begin
        state_q     <= OFF;
        activated_q <= 1'b0;
      end else begin
        unique case (state_q)
          OFF: begin
            if (user_activate_i) begin
              state_q     <= ARMED;
              activated_q <= 1'b1;
            end
          end
          ARMED:   if (qual_hit)   state_q <= TRACING;
          TRACING: if (unqual_hit) state_q <= ARMED;
          default: begin
            state_q     <= OFF;
            activated_q <= 1'b0;
          end
        endcase
      end

      if (state_q != OFF && qual_hit) begin
        last_addr_q <= iaddr_i;
      end

      // Activation restarts the count; a live increment beats clear_i.
      if (state_q == OFF && user_activate_i && !deact) begin
        qual_cnt_q <= '0;
      end else if (state_q != OFF && qual_hit) begin
        if (qual_cnt_q != CNT_MAX) qual_cnt_q <= qual_cnt_q + CNT_ONE;
      end else if (clear_i) begin
        qual_cnt_q <= '0;
      end

      if (drop) begin
        if (drop_cnt_q != CNT_MAX) drop_cnt_q <= drop_cnt_q + CNT_ONE;
        overflow_q <= 1'b1;
      end else if (clear_i) begin
        drop_cnt_q <= '0;
        overflow_q <= 1'b0;
      end
    end
  end

  trdb_evt_reg u_evt_reg (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .in_valid_i  (new_valid),
    .in_evt_i    (new_evt),
    .out_ready_i (evt.evt_ready),
    .out_valid_o (out_valid),
    .out_evt_o   (out_evt),
    .drop_o      (drop)
  );

  assign evt.evt_valid     = out_valid;
  assign evt.evt_type      = out_evt.typ;
  assign evt.evt_addr      = out_evt.addr;
  assign trace_activated_o = activated_q;
  assign state_o           = state_q;
  assign qual_cnt_o        = qual_cnt_q;
  assign drop_cnt_o        = drop_cnt_q;
  assign overflow_o        = overflow_q;

endmodule

// File: tb/tb_trdb_trace_ctrl.sv
module tb_trdb_trace_ctrl;
  import trdb_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n = 1'b0;
  logic            act = 1'b0, dea = 1'b0, clr = 1'b0, iv = 1'b0, q = 1'b0, rq = 1'b0;
  logic [XLEN-1:0] ia = '0;

  logic        act_o, ovf, act_o2, ovf2;
  logic [1:0]  st, st2;
  logic [15:0] qc, dc;
  logic [1:0]  qc2, dc2;

  trdb_trace_ctrl_if evt_if ();
  trdb_trace_ctrl_if evt_if2 ();
  assign evt_if2.evt_ready = evt_if.evt_ready;

  trdb_trace_ctrl #(.CNT_W(16)) dut (
    .clk_i(clk), .rst_ni(rst_n), .user_activate_i(act), .user_deactivate_i(dea),
    .clear_i(clr), .ivalid_i(iv), .iaddr_i(ia), .trace_qualified_i(q),
    .trace_req_deactivate_i(rq), .trace_activated_o(act_o), .evt(evt_if),
    .state_o(st), .qual_cnt_o(qc), .drop_cnt_o(dc), .overflow_o(ovf)
  );

  trdb_trace_ctrl #(.CNT_W(2)) dut_small (
    .clk_i(clk), .rst_ni(rst_n), .user_activate_i(act), .user_deactivate_i(dea),
    .clear_i(clr), .ivalid_i(iv), .iaddr_i(ia), .trace_qualified_i(q),
    .trace_req_deactivate_i(rq), .trace_activated_o(act_o2), .evt(evt_if2),
    .state_o(st2), .qual_cnt_o(qc2), .drop_cnt_o(dc2), .overflow_o(ovf2)
  );

  // Reference model: mode 0=off, 1=armed, 2=tracing; counters kept unbounded
  // and clipped to the counter width when compared.
  int              m_mode = 0;
  logic [XLEN-1:0] m_last = '0;
  longint          m_qual = 0, m_drop = 0;
  bit              m_ovf = 0, m_full = 0;
  trdb_evt_t       exp_q[$];

  int errors = 0, checks = 0;

  function automatic longint mn(longint a, longint b);
    return (a < b) ? a : b;
  endfunction

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_last = '0; m_qual = 0; m_drop = 0; m_ovf = 0; m_full = 0;
    exp_q.delete();
  endtask

  // Applies the rules for one clock edge using the inputs currently driven.
  task automatic model_step();
    bit        kill, gen, inc;
    trdb_evt_t e;
    kill = dea | (iv & rq);
    gen  = 0;
    e    = '0;
    inc  = (m_mode != 0) && iv && q;
    if (kill) begin
      if (m_mode == 2) begin gen = 1; e.typ = EVT_STOP; e.addr = m_last; end
      m_mode = 0;
    end else if (m_mode == 0 && act) begin
      m_mode = 1;
      m_qual = 0;
    end else if (m_mode == 1 && iv && q) begin
      gen = 1; e.typ = EVT_START; e.addr = ia;
      m_mode = 2;
    end else if (m_mode == 2 && iv && !q) begin
      gen = 1; e.typ = EVT_STOP; e.addr = m_last;
      m_mode = 1;
    end
    if (inc) begin
      m_qual = m_qual + 1;
      m_last = ia;
    end else if (clr) begin
      m_qual = 0;
    end
    if (gen) begin
      if (!m_full || evt_if.evt_ready) begin
        exp_q.push_back(e);
        m_full = 1;
      end else begin
        m_drop = m_drop + 1;
        m_ovf  = 1;
      end
    end else if (clr) begin
      m_drop = 0;
      m_ovf  = 0;
    end
    if (!gen && m_full && evt_if.evt_ready) m_full = 0;
  endtask

  task automatic cyc(input bit a, input bit d, input bit c, input bit v, input bit qq,
                     input bit r, input logic [XLEN-1:0] addr, input bit rdy);
    act = a; dea = d; clr = c; iv = v; q = qq; rq = r; ia = addr;
    evt_if.evt_ready = rdy;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle(input bit rdy);
    cyc(0, 0, 0, 0, 0, 0, '0, rdy);
  endtask

  // Monitor: per-cycle status checks and scoreboard pops on handshakes.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("state", {62'd0, st}, m_mode);
      chk("activated", {63'd0, act_o}, {63'd0, m_mode != 0});
      chk("qual_cnt", {48'd0, qc}, mn(m_qual, 65535));
      chk("drop_cnt", {48'd0, dc}, mn(m_drop, 65535));
      chk("overflow", {63'd0, ovf}, {63'd0, m_ovf});
      chk("evt_valid", {63'd0, evt_if.evt_valid}, {63'd0, m_full});
      chk("small_qual_cnt", {62'd0, qc2}, mn(m_qual, 3));
      chk("small_drop_cnt", {62'd0, dc2}, mn(m_drop, 3));
      if (evt_if.evt_valid && evt_if.evt_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_evt", 64'd1, 64'd0);
        end else begin
          trdb_evt_t e;
          e = exp_q.pop_front();
          $display("evt %s addr=%h (expected %s addr=%h)",
                   evt_if.evt_type ? "STOP " : "START", evt_if.evt_addr,
                   e.typ ? "STOP " : "START", e.addr);
          chk("evt_type", {63'd0, evt_if.evt_type}, {63'd0, e.typ});
          chk("evt_addr", {32'd0, evt_if.evt_addr}, {32'd0, e.addr});
        end
      end
    end
  end

  task automatic check_all_zero(input string tag);
    chk({tag, "_state"}, {62'd0, st}, 0);
    chk({tag, "_activated"}, {63'd0, act_o}, 0);
    chk({tag, "_evt_valid"}, {63'd0, evt_if.evt_valid}, 0);
    chk({tag, "_evt_type"}, {63'd0, evt_if.evt_type}, 0);
    chk({tag, "_evt_addr"}, {32'd0, evt_if.evt_addr}, 0);
    chk({tag, "_counts"}, {31'd0, ovf, dc, qc}, 0);
    chk({tag, "_small"}, {58'd0, act_o2, ovf2, dc2, qc2}, 0);
  endtask

  initial begin
    evt_if.evt_ready = 1'b0;
    #13;
    check_all_zero("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // 1: START(0x100), STOP(0x104), qual_cnt 2, back to ARMED.
    cyc(1, 0, 0, 0, 0, 0, '0, 1);
    cyc(0, 0, 0, 1, 1, 0, 32'h100, 1);
    cyc(0, 0, 0, 1, 1, 0, 32'h104, 1);
    cyc(0, 0, 0, 1, 0, 0, 32'h108, 1);
    chk("t1_qual_cnt", {48'd0, qc}, 2);
    chk("t1_state", {62'd0, st}, ARMED);
    idle(1);

    // 2: deactivate from TRACING gives STOP(0x200) and OFF.
    cyc(0, 0, 0, 1, 1, 0, 32'h200, 1);
    cyc(0, 1, 0, 0, 0, 0, '0, 1);
    chk("t2_activated", {63'd0, act_o}, 0);
    idle(1);

    // 3: filter deactivation while ARMED; then activate+deactivate from OFF.
    cyc(1, 0, 0, 0, 0, 0, '0, 1);
    cyc(0, 0, 0, 1, 0, 1, 32'h250, 1);
    chk("t3_state", {62'd0, st}, OFF);
    cyc(1, 1, 0, 0, 0, 0, '0, 1);
    chk("t3_both_state", {62'd0, st}, OFF);

    // 4: stalled consumer: START held, STOP dropped; clear resets counters.
    cyc(1, 0, 0, 0, 0, 0, '0, 0);
    cyc(0, 0, 0, 1, 1, 0, 32'h300, 0);
    cyc(0, 0, 0, 1, 0, 0, 32'h304, 0);
    idle(0);
    chk("t4_drop_cnt", {48'd0, dc}, 1);
    chk("t4_held_addr", {32'd0, evt_if.evt_addr}, 32'h300);
    cyc(0, 0, 1, 0, 0, 0, '0, 0);
    chk("t4_clear", {47'd0, ovf, dc}, 0);
    idle(1);
    idle(1);

    // 5: always ready, alternating qualification: nothing dropped.
    for (int i = 0; i < 12; i++) cyc(0, 0, 0, 1, i[0] == 1'b0, 0, 32'h400 + 4 * i, 1);
    chk("t5_drop_cnt", {48'd0, dc}, 0);

    // 6: small counter saturates at 3.
    cyc(0, 1, 0, 0, 0, 0, '0, 1);
    cyc(1, 0, 0, 0, 0, 0, '0, 1);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 1, 1, 0, 32'h500 + 4 * i, 1);
    chk("t6_small_sat", {62'd0, qc2}, 3);

    // Reset mid-trace with an event pending.
    cyc(0, 0, 0, 1, 0, 0, 32'h600, 0);
    #2 rst_n = 1'b0;
    #1 check_all_zero("midrst");
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      bit a, d, c, v, qq, r, rdy;
      a   = ($urandom_range(0, 15) == 0);
      d   = ($urandom_range(0, 31) == 0);
      v   = $urandom_range(0, 1);
      qq  = $urandom_range(0, 1);
      r   = ($urandom_range(0, 15) == 0);
      rdy = ($urandom_range(0, 3) != 0);
      c   = !v && !d && ($urandom_range(0, 15) == 0);
      cyc(a, d, c, v, qq, r, {$urandom_range(0, 32'h3FFF), 2'b00}, rdy);
    end

    for (int i = 0; i < 4; i++) idle(1);
    chk("drain_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
